con_chk: RTL and testbench
==========================

Name: con_chk

Overview:
- Receive-side checker for the 3-bit up/down counter output bus (s2,s1,s0) and its direction control x.
- Samples the code every clock and predicts the next code from the previous sample and direction.
- Declares lock after a run of correct steps and flags/counts step errors while locked.
- Sits at the consumer end of the counter, for bring-up and in-system monitoring.

Parameters:
- W, 3: code width (matches s2..s0).
- LOCK_N, 4: consecutive good steps needed to enter LOCK (1..15).
- LOSS_N, 2: consecutive bad steps in LOCK that drop to ACQ (1..15).
- ERRW, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset, synchronous, active-high.
- x  in  1  counter direction: 1 = up, 0 = down.
- s_in  in  W  observed counter code; s_in[2] = s2, s_in[0] = s0.
- lock  out  1  checker locked to a valid count sequence.
- err  out  1  one-cycle pulse per step error detected while in LOCK.
- err_cnt  out  ERRW  saturating count of errors flagged on err.
- dir_obs  out  1  direction of the last good step (1 = up).

Behaviour:
- Reset: synchronous on res=1 at a rising clk edge.
  - lock=0, err=0, err_cnt=0, dir_obs=0.
  - State=SEEK; good/bad counters cleared; prev cleared.
  - Reset wins over all other events, including mid-LOCK.
- Registers: every edge, prev<=s_in and xp<=x (not in reset).
- Expected code: exp = prev+1 if xp=1, else prev-1, modulo 2^W.
  - Wrap is legal: 7->0 up, 0->7 down.
- Step classification:
  - Good: s_in==exp.
  - Bad: anything else, including s_in==prev.
- SEEK: first edge after reset only captures prev/xp, then goes to ACQ with good=0. No comparison is made.
- ACQ:
  - Good step: good++ and dir_obs<=xp. When good reaches LOCK_N, go to LOCK with bad=0 and lock<=1.
  - Bad step: good<=0; stay in ACQ.
  - err is never asserted in ACQ.
- LOCK:
  - Good step: bad<=0; dir_obs<=xp.
  - Bad step: err<=1 for one cycle; err_cnt++ (saturating at 2^ERRW-1); bad++.
  - When bad reaches LOSS_N: go to ACQ with good=0 and lock<=0, in the same edge as that error pulse.
- Latency: all outputs are registered. A response appears on the edge that samples the offending or completing s_in, so it is visible one cycle after that s_in was presented.
- Simultaneous events: a direction change on x takes effect for the next step (via xp). A step that is both bad and the LOSS_N-th error still counts and pulses err.
- err_cnt holds at saturation; err still pulses.

Optional Feature:
- Macro: CON_CHK_HOLD_EN.
- Defined: s_in==prev (counter held) is neutral.
  - No good/bad counter change, no err, prev unchanged.
  - For the next step, exp is still computed from the held value.
- Undefined: a hold is a bad step, as above.

Decomposition:
- Package con_pkg holds:
  - State enum {SEEK, ACQ, LOCK}.
  - Default code width constant CON_W=3.
  - Direction constants DIR_UP=1, DIR_DN=0.
- One sub-module, con_sat_cnt: parameterised-width saturating counter with sync clear and inc. Used for err_cnt.
- good/bad counters stay inline.

Test Plan:
- Up lock and wrap (defaults): res=1 for 2 cycles; x=1; s_in=0,1,2,3,4,5,6,7,0,1 -> lock=1 after the sample of 4, stays 1 through 7->0, dir_obs=1, err never 1, err_cnt=0.
- Single glitch in LOCK: locked up sequence ...2,3,5,6,7 -> err pulses once (on the 5), err_cnt=1, lock stays 1; 5->6 is good.
- Loss of lock: locked, then 3,5,1 -> two err pulses, err_cnt=2, lock falls with the second pulse, state ACQ. 2,3,4,5 then relocks.
- Direction change: locked up at 5; x=0 for following steps; s_in=4,3,2 -> no err, dir_obs=0 after the first down step.
- Reset mid-operation: locked with err_cnt=3; res=1 for 1 cycle -> next cycle lock=0, err=0, err_cnt=0, dir_obs=0. Relock needs 1+LOCK_N samples.
- Saturation and hold: with ERRW=2, force 5 isolated errors in LOCK -> err_cnt=3, 5 err pulses. s_in 3,3,4 up:
  - With CON_CHK_HOLD_EN: no err.
  - Without it: one err.

Source files
------------

// File: rtl/con_pkg.sv
// Shared types and constants for the con_chk up/down counter checker.
// Contents: checker state enum, default code width, direction encodings.
package con_pkg;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } con_state_t;

    localparam int   CON_W  = 3;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/con_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  in   clock, rising edge
//   res  in   synchronous active-high reset
//   clr  in   synchronous clear
//   inc  in   increment request, ignored once the counter is full
//   cnt  out  current count
module con_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (res || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/con_chk.sv
// Receive-side checker for a W-bit up/down counter bus and its direction.
// Predicts each code from the previous sample and direction, locks after
// LOCK_N consecutive good steps, flags and counts bad steps while locked,
// and drops lock after LOSS_N consecutive bad steps.
// Build option: define CON_CHK_HOLD_EN to treat a held code (s_in == prev)
// as neutral instead of as a bad step.
// Ports:
//   clk      in   system clock, rising edge
//   res      in   synchronous active-high reset
//   x        in   counter direction (1 = up, 0 = down)
//   s_in     in   observed counter code
//   lock     out  locked to a valid count sequence
//   err      out  one-cycle pulse per step error while locked
//   err_cnt  out  saturating count of err pulses
//   dir_obs  out  direction of the last good step
module con_chk
    import con_pkg::*;
#(
    parameter int W      = CON_W,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 2,
    parameter int ERRW   = 8
) (
    input  logic            clk,
    input  logic            res,
    input  logic            x,
    input  logic [W-1:0]    s_in,
    output logic            lock,
    output logic            err,
    output logic [ERRW-1:0] err_cnt,
    output logic            dir_obs
);

    con_state_t   state, state_nx;
    logic [W-1:0] prev, exp_code;
    logic         xp;
    logic [3:0]   good, good_nx;
    logic [3:0]   bad, bad_nx;
    logic         lock_nx, err_nx, dir_nx, cnt_inc;
    logic         is_good, step_en;

    // Modulo-2^W arithmetic makes 7->0 up and 0->7 down legal steps.
    assign exp_code = (xp == DIR_UP) ? prev + W'(1) : prev - W'(1);
    assign is_good  = (s_in == exp_code);

`ifdef CON_CHK_HOLD_EN
    // A held code neither advances nor breaks the good/bad runs.
    assign step_en = (s_in != prev);
`else
    assign step_en = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        good_nx  = good;
        bad_nx   = bad;
        lock_nx  = lock;
        err_nx   = 1'b0;
        dir_nx   = dir_obs;
        cnt_inc  = 1'b0;
        case (state)
            SEEK: begin
                // First sample only seeds prev/xp; nothing to compare yet.
                state_nx = ACQ;
                good_nx  = '0;
            end
            ACQ: begin
                if (step_en) begin
                    if (is_good) begin
                        good_nx = good + 4'd1;
                        dir_nx  = xp;
                        if (good + 4'd1 == 4'(LOCK_N)) begin
                            state_nx = LOCK;
                            bad_nx   = '0;
                            lock_nx  = 1'b1;
                        end
                    end else begin
                        good_nx = '0;
                    end
                end
            end
            LOCK: begin
                if (step_en) begin
                    if (is_good) begin
                        bad_nx = '0;
                        dir_nx = xp;
                    end else begin
                        err_nx  = 1'b1;
                        cnt_inc = 1'b1;
                        bad_nx  = bad + 4'd1;
                        // Losing lock shares the edge with the final err pulse.
                        if (bad + 4'd1 == 4'(LOSS_N)) begin
                            state_nx = ACQ;
                            good_nx  = '0;
                            bad_nx   = '0;
                            lock_nx  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nx = SEEK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state   <= SEEK;
            good    <= '0;
            bad     <= '0;
            prev    <= '0;
            xp      <= DIR_DN;
            lock    <= 1'b0;
            err     <= 1'b0;
            dir_obs <= DIR_DN;
        end else begin
            state   <= state_nx;
            good    <= good_nx;
            bad     <= bad_nx;
            prev    <= s_in;
            xp      <= x;
            lock    <= lock_nx;
            err     <= err_nx;
            dir_obs <= dir_nx;
        end
    end

    con_sat_cnt #(.W(ERRW)) u_err_cnt (
        .clk (clk),
        .res (res),
        .clr (1'b0),
        .inc (cnt_inc),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_con_chk.sv
// Directed bench for con_chk: two instances (ERRW=8 and ERRW=2) share stimulus.
module tb_con_chk;

    logic       clk = 1'b0;
    logic       res;
    logic       x;
    logic [2:0] s_in;

    logic       lock_a, err_a, dir_a;
    logic [7:0] cnt_a;
    logic       lock_b, err_b, dir_b;
    logic [1:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    con_chk #(.W(3), .LOCK_N(4), .LOSS_N(2), .ERRW(8)) dut_a (
        .clk(clk), .res(res), .x(x), .s_in(s_in),
        .lock(lock_a), .err(err_a), .err_cnt(cnt_a), .dir_obs(dir_a)
    );

    con_chk #(.W(3), .LOCK_N(4), .LOSS_N(2), .ERRW(2)) dut_b (
        .clk(clk), .res(res), .x(x), .s_in(s_in),
        .lock(lock_b), .err(err_b), .err_cnt(cnt_b), .dir_obs(dir_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic l, input logic e, input logic d);
        chk({tag, ".lock_a"}, 32'(lock_a), 32'(l));
        chk({tag, ".err_a"},  32'(err_a),  32'(e));
        chk({tag, ".dir_a"},  32'(dir_a),  32'(d));
        chk({tag, ".lock_b"}, 32'(lock_b), 32'(l));
        chk({tag, ".err_b"},  32'(err_b),  32'(e));
        chk({tag, ".dir_b"},  32'(dir_b),  32'(d));
    endtask

    task automatic chk_cnt(input string tag, input int c8, input int c2);
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'(c8));
        chk({tag, ".cnt_b"}, 32'(cnt_b), 32'(c2));
    endtask

    // x is the direction for the step from this sample to the next one.
    task automatic step(input logic [2:0] s, input logic d);
        s_in = s;
        x    = d;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] sat_seq [10] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        res = 1'b1; x = 1'b0; s_in = 3'd0;
        // Reset for two cycles
        step(3'd5, 1'b1);
        step(3'd5, 1'b1);
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 0, 0);
        res = 1'b0;

        // Up count with wrap: lock on the sample of 4
        step(3'd0, 1'b1);
        chk_out("seek", 1'b0, 1'b0, 1'b0);
        step(3'd1, 1'b1);
        step(3'd2, 1'b1);
        step(3'd3, 1'b1);
        chk_out("acq3", 1'b0, 1'b0, 1'b1);
        step(3'd4, 1'b1);
        chk_out("lock4", 1'b1, 1'b0, 1'b1);
        for (int v = 5; v < 10; v++) begin
            step(3'(v), 1'b1);
            chk_out("wrap", 1'b1, 1'b0, 1'b1);
        end
        chk_cnt("wrap", 0, 0);

        // Single glitch in LOCK (prev = 1)
        step(3'd2, 1'b1);
        step(3'd3, 1'b1);
        step(3'd5, 1'b1);
        chk_out("glitch", 1'b1, 1'b1, 1'b1);
        chk_cnt("glitch", 1, 1);
        step(3'd6, 1'b1);
        chk_out("glitch_rec", 1'b1, 1'b0, 1'b1);
        step(3'd7, 1'b1);

        // Loss of lock: two consecutive bad steps
        step(3'd0, 1'b1);
        step(3'd1, 1'b1);
        step(3'd2, 1'b1);
        step(3'd3, 1'b1);
        step(3'd5, 1'b1);
        chk_out("loss1", 1'b1, 1'b1, 1'b1);
        chk_cnt("loss1", 2, 2);
        step(3'd1, 1'b1);
        chk_out("loss2", 1'b0, 1'b1, 1'b1);
        chk_cnt("loss2", 3, 3);
        // Bad step in ACQ must not pulse err
        step(3'd7, 1'b1);
        chk_out("acq_bad", 1'b0, 1'b0, 1'b1);
        chk_cnt("acq_bad", 3, 3);
        step(3'd0, 1'b1);
        step(3'd1, 1'b1);
        step(3'd2, 1'b1);
        chk_out("relock_pre", 1'b0, 1'b0, 1'b1);
        step(3'd3, 1'b1);
        chk_out("relock", 1'b1, 1'b0, 1'b1);

        // Direction change: x=0 presented with 4, takes effect for the next step
        step(3'd4, 1'b0);
        chk_out("dir_last_up", 1'b1, 1'b0, 1'b1);
        step(3'd3, 1'b0);
        chk_out("dir_down1", 1'b1, 1'b0, 1'b0);
        step(3'd2, 1'b0);
        step(3'd1, 1'b0);
        chk_out("dir_down3", 1'b1, 1'b0, 1'b0);
        chk_cnt("dir", 3, 3);

        // Reset mid-LOCK, then relock after 1+LOCK_N samples
        res = 1'b1;
        step(3'd0, 1'b1);
        chk_out("mid_reset", 1'b0, 1'b0, 1'b0);
        chk_cnt("mid_reset", 0, 0);
        res = 1'b0;
        step(3'd0, 1'b1);
        step(3'd1, 1'b1);
        step(3'd2, 1'b1);
        step(3'd3, 1'b1);
        chk_out("rst_relock_pre", 1'b0, 1'b0, 1'b1);
        step(3'd4, 1'b1);
        chk_out("rst_relock", 1'b1, 1'b0, 1'b1);

        // Five isolated errors: bad at even index, good at odd index
        for (int i = 0; i < 10; i++) begin
            step(sat_seq[i], 1'b1);
            if (i % 2 == 0) begin
                chk_out("sat_err", 1'b1, 1'b1, 1'b1);
                chk_cnt("sat_err", i / 2 + 1, (i / 2 + 1 > 3) ? 3 : i / 2 + 1);
            end else begin
                chk_out("sat_good", 1'b1, 1'b0, 1'b1);
            end
        end

        // Held code: 3,3,4 counting up
        step(3'd6, 1'b1);
        step(3'd7, 1'b1);
        step(3'd0, 1'b1);
        step(3'd1, 1'b1);
        step(3'd2, 1'b1);
        step(3'd3, 1'b1);
        step(3'd3, 1'b1);
`ifdef CON_CHK_HOLD_EN
        chk_out("hold", 1'b1, 1'b0, 1'b1);
        chk_cnt("hold", 5, 3);
`else
        chk_out("hold", 1'b1, 1'b1, 1'b1);
        chk_cnt("hold", 6, 3);
`endif
        step(3'd4, 1'b1);
        chk_out("hold_next", 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
